// File: rtl/cla16_seq_mult_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// Master drives operands and accepts products; slave is the multiplier.
interface cla16_seq_mult_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/cla16_seq_mult.sv
// 16x16 unsigned shift-add multiplier built around one CLA16.
// Define CLA16_SEQ_MULT_EARLY_TERM_EN to stop once the multiplier is exhausted.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        gm
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp, cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    cg[0] = c_in;
    cg[1] = gg[0] | (gp[0] & c_in);
    cg[2] = gg[1] | (gp[1] & gg[0])
          | (gp[1] & gp[0] & c_in);
    cg[3] = gg[2] | (gp[2] & gg[1])
          | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    sum = p ^ c;
    gm  = gg[3]
        | (gp[3] & gg[2])
        | (gp[3] & gp[2] & gg[1])
        | (gp[3] & gp[2] & gp[1] & gg[0]);
  end
endmodule

module cla16_seq_mult #(
  parameter int ITER = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla16_seq_mult_if.slave       bus,
  output logic                  busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
  localparam logic [1:0] ALIGN = 2'd3;
`endif

  logic [1:0]  state;
  logic [15:0] m, h, q;
  logic [4:0]  cnt;
  logic [15:0] sum;
  logic        gm;
  logic [31:0] hq_step;
  logic        last;
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
  logic [15:0] r;
`endif

  cla16 u_cla (
    .a    (h),
    .b    (m),
    .c_in (1'b0),
    .sum  (sum),
    .gm   (gm)
  );

  // Carry-out of H+M becomes the new top bit of the accumulator.
  always_comb begin
    hq_step = {1'b0, h, q[15:1]};
    if (q[0])
      hq_step = {gm, sum, q[15:1]};
  end

  assign last          = (cnt == 5'(ITER - 1));
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = {h, q};
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      h     <= '0;
      q     <= '0;
      cnt   <= '0;
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
      r     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m     <= bus.a;
            q     <= bus.b;
            h     <= '0;
            cnt   <= '0;
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
            r     <= bus.b;
`endif
            state <= RUN;
          end
        end
        RUN: begin
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
          if (r == '0) begin
            state <= ALIGN;
          end else begin
            {h, q} <= hq_step;
            cnt    <= cnt + 5'd1;
            r      <= r >> 1;
            if (last)
              state <= DONE;
          end
`else
          {h, q} <= hq_step;
          cnt    <= cnt + 5'd1;
          if (last)
            state <= DONE;
`endif
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
`ifdef CLA16_SEQ_MULT_EARLY_TERM_EN
        // Skipped iterations only shifted right; apply them in one go.
        ALIGN: begin
          {h, q} <= {h, q} >> (5'd16 - cnt);
          state  <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
